// File: rtl/r2sdf_butterfly.sv
// r2sdf_butterfly: radix-2 single-path delay-feedback butterfly stage controller
module r2sdf_butterfly #(
    parameter int WIDTH = 24,
    parameter int DELAY = 8,
    parameter int SCALE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] dataIn_R,
    input  logic signed [WIDTH-1:0] dataIn_I,
    input  logic signed [WIDTH-1:0] shOut_R,
    input  logic signed [WIDTH-1:0] shOut_I,
    output logic signed [WIDTH-1:0] shIn_R,
    output logic signed [WIDTH-1:0] shIn_I,
    output logic signed [WIDTH-1:0] dataOut_R,
    output logic signed [WIDTH-1:0] dataOut_I,
    output logic                    out_valid,
    output logic                    out_sof,
    output logic                    err
);
    localparam int CW = $clog2(2 * DELAY);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            bf_done, bf_done_n;
    logic            run_cyc, flush_cyc, active, phase, last_flush, err_set;
    logic signed [WIDTH-1:0] x_r, x_i;
    logic signed [WIDTH:0]   sum_r, sum_i, dif_r, dif_i;

    function automatic logic signed [WIDTH-1:0] reduce(input logic signed [WIDTH:0] v);
        return SCALE != 0 ? v[WIDTH:1] :
               v[WIDTH] != v[WIDTH-1] ? {v[WIDTH], {(WIDTH-1){~v[WIDTH]}}} : v[WIDTH-1:0];
    endfunction

    // An IDLE cycle with in_valid already carries frame sample 0
    assign run_cyc    = rst && ((state == RUN && !(cnt == '0 && !in_valid)) || (state == IDLE && in_valid));
    assign flush_cyc  = state == FLUSH || (state == RUN && cnt == '0 && !in_valid);
    assign active     = run_cyc || flush_cyc;
    assign phase      = cnt[CW-1];
    assign last_flush = state == FLUSH && cnt == CW'(DELAY - 1);
    assign err_set    = (state == RUN && cnt != '0 && !in_valid) || (state == FLUSH && in_valid);
    assign in_ready   = state != FLUSH;

    assign x_r   = run_cyc && in_valid ? dataIn_R : '0;
    assign x_i   = run_cyc && in_valid ? dataIn_I : '0;
    assign sum_r = {shOut_R[WIDTH-1], shOut_R} + {x_r[WIDTH-1], x_r};
    assign sum_i = {shOut_I[WIDTH-1], shOut_I} + {x_i[WIDTH-1], x_i};
    assign dif_r = {shOut_R[WIDTH-1], shOut_R} - {x_r[WIDTH-1], x_r};
    assign dif_i = {shOut_I[WIDTH-1], shOut_I} - {x_i[WIDTH-1], x_i};

    assign shIn_R = phase ? reduce(dif_r) : x_r;
    assign shIn_I = phase ? reduce(dif_i) : x_i;

    always_comb begin
        state_n   = state == IDLE ? (in_valid ? RUN : IDLE) :
                    state == RUN  ? (cnt == '0 && !in_valid ? FLUSH : RUN) :
                    last_flush    ? IDLE : FLUSH;
        cnt_n     = last_flush || (state == IDLE && !in_valid) ? '0 : cnt + CW'(1);
        bf_done_n = last_flush ? 1'b0 : bf_done || (run_cyc && phase && cnt == '1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bf_done   <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            dataOut_R <= '0;
            dataOut_I <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bf_done   <= bf_done_n;
            err       <= err || err_set;
            out_valid <= (run_cyc && phase) || (active && !phase && bf_done);
            out_sof   <= run_cyc && cnt == CW'(DELAY);
            if (active) begin
                dataOut_R <= phase ? reduce(sum_r) : shOut_R;
                dataOut_I <= phase ? reduce(sum_i) : shOut_I;
            end
        end
    end
endmodule

// File: tb/tb_r2sdf_butterfly.sv
// tb_r2sdf_butterfly: directed checks of the butterfly stage with a modelled delay line
module tb_r2sdf_butterfly;
    logic clk = 1'b0;
    logic rst, in_valid;
    logic signed [7:0] din_r, din_i;

    logic a_rdy, a_ov, a_sof, a_err;
    logic signed [7:0] a_shi_r, a_shi_i, a_sho_r, a_sho_i, a_dr, a_di;
    logic b_rdy, b_ov, b_sof, b_err;
    logic signed [7:0] b_shi_r, b_shi_i, b_sho_r, b_sho_i, b_dr, b_di;
    logic signed [7:0] dla_r [2], dla_i [2], dlb_r [2], dlb_i [2];

    int n_checks = 0, n_pass = 0, cyc = 0, first_v = -1, last_v = -1;
    int qa_r[$], qa_i[$], qa_sof[$], qb_r[$];
    logic last_rdy;

    always #5 clk = ~clk;

    r2sdf_butterfly #(.WIDTH(8), .DELAY(2), .SCALE(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy),
        .dataIn_R(din_r), .dataIn_I(din_i), .shOut_R(a_sho_r), .shOut_I(a_sho_i),
        .shIn_R(a_shi_r), .shIn_I(a_shi_i), .dataOut_R(a_dr), .dataOut_I(a_di),
        .out_valid(a_ov), .out_sof(a_sof), .err(a_err));

    r2sdf_butterfly #(.WIDTH(8), .DELAY(2), .SCALE(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy),
        .dataIn_R(din_r), .dataIn_I(din_i), .shOut_R(b_sho_r), .shOut_I(b_sho_i),
        .shIn_R(b_shi_r), .shIn_I(b_shi_i), .dataOut_R(b_dr), .dataOut_I(b_di),
        .out_valid(b_ov), .out_sof(b_sof), .err(b_err));

    assign a_sho_r = dla_r[1];
    assign a_sho_i = dla_i[1];
    assign b_sho_r = dlb_r[1];
    assign b_sho_i = dlb_i[1];

    always @(posedge clk) begin
        dla_r[0] <= a_shi_r; dla_r[1] <= dla_r[0];
        dla_i[0] <= a_shi_i; dla_i[1] <= dla_i[0];
        dlb_r[0] <= b_shi_r; dlb_r[1] <= dlb_r[0];
        dlb_i[0] <= b_shi_i; dlb_i[1] <= dlb_i[0];
    end

    function automatic int qget(input int q[$], input int i);
        return i < q.size() ? q[i] : 9999;
    endfunction

    task automatic clear();
        qa_r.delete(); qa_i.delete(); qa_sof.delete(); qb_r.delete();
        cyc = 0; first_v = -1; last_v = -1;
    endtask

    task automatic step(input logic v, input int r, input int i);
        in_valid = v;
        din_r = 8'(r);
        din_i = 8'(i);
        #1 last_rdy = a_rdy;
        @(posedge clk);
        #1;
        if (a_ov) begin
            qa_r.push_back(int'(a_dr));
            qa_i.push_back(int'(a_di));
            qa_sof.push_back(int'(a_sof));
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (b_ov) qb_r.push_back(int'(b_dr));
        cyc++;
    endtask

    task automatic run_seq(input int s[8], input int n, input int idle);
        for (int k = 0; k < n; k++) step(1'b1, s[k], -s[k]);
        for (int k = 0; k < idle; k++) step(1'b0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        din_r = '0;
        din_i = '0;
        #1;
        n_checks++; if (a_dr !== 8'sd0 || a_di !== 8'sd0) $display("FAIL reset_data: got %0d/%0d expected 0/0", a_dr, a_di); else n_pass++;
        n_checks++; if (a_ov !== 1'b0 || a_sof !== 1'b0) $display("FAIL reset_flags: got valid=%b sof=%b expected 0/0", a_ov, a_sof); else n_pass++;
        n_checks++; if (a_err !== 1'b0 || b_err !== 1'b0) $display("FAIL reset_err: got %b/%b expected 0/0", a_err, b_err); else n_pass++;
        n_checks++; if (a_rdy !== 1'b1 || a_shi_r !== 8'sd0) $display("FAIL reset_ready_shin: got rdy=%b shin=%0d expected 1/0", a_rdy, a_shi_r); else n_pass++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        step(1'b0, 0, 0);
    endtask

    task automatic test_single();
        int e[4];
        e = '{4, 6, -2, -2};
        clear();
        run_seq('{1, 2, 3, 4, 0, 0, 0, 0}, 4, 4);
        n_checks++; if (qa_r.size() != 4) $display("FAIL single_count: got %0d expected 4", qa_r.size()); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (qget(qa_r, k) != e[k]) $display("FAIL single_r[%0d]: got %0d expected %0d", k, qget(qa_r, k), e[k]); else n_pass++;
            n_checks++; if (qget(qa_i, k) != -e[k]) $display("FAIL single_i[%0d]: got %0d expected %0d", k, qget(qa_i, k), -e[k]); else n_pass++;
            n_checks++; if (qget(qa_sof, k) != (k == 0 ? 1 : 0)) $display("FAIL single_sof[%0d]: got %0d expected %0d", k, qget(qa_sof, k), k == 0 ? 1 : 0); else n_pass++;
        end
        n_checks++; if (first_v != 2 || last_v != 5) $display("FAIL single_timing: got first=%0d last=%0d expected 2/5", first_v, last_v); else n_pass++;
        n_checks++; if (a_err !== 1'b0 || last_rdy !== 1'b1) $display("FAIL single_idle: got err=%b rdy=%b expected 0/1", a_err, last_rdy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e[8];
        e = '{4, 6, -2, -2, 12, 14, -2, -2};
        clear();
        run_seq('{1, 2, 3, 4, 5, 6, 7, 8}, 8, 4);
        n_checks++; if (qa_r.size() != 8 || last_v - first_v != 7) $display("FAIL b2b_contiguous: got count=%0d span=%0d expected 8/7", qa_r.size(), last_v - first_v); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (qget(qa_r, k) != e[k]) $display("FAIL b2b_r[%0d]: got %0d expected %0d", k, qget(qa_r, k), e[k]); else n_pass++;
            n_checks++; if (qget(qa_sof, k) != ((k % 4) == 0 ? 1 : 0)) $display("FAIL b2b_sof[%0d]: got %0d expected %0d", k, qget(qa_sof, k), (k % 4) == 0 ? 1 : 0); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        clear();
        run_seq('{100, 0, 100, 0, 0, 0, 0, 0}, 4, 4);
        n_checks++; if (qget(qa_r, 0) != 127) $display("FAIL sat_sum_hi: got %0d expected 127", qget(qa_r, 0)); else n_pass++;
        n_checks++; if (qget(qa_i, 0) != -128) $display("FAIL sat_sum_lo: got %0d expected -128", qget(qa_i, 0)); else n_pass++;
        n_checks++; if (qget(qb_r, 0) != 100) $display("FAIL scaled_no_overflow: got %0d expected 100", qget(qb_r, 0)); else n_pass++;
        clear();
        run_seq('{-100, 0, 100, 0, 0, 0, 0, 0}, 4, 4);
        n_checks++; if (qget(qa_r, 2) != -128) $display("FAIL sat_diff_lo: got %0d expected -128", qget(qa_r, 2)); else n_pass++;
        n_checks++; if (qget(qa_i, 2) != 127) $display("FAIL sat_diff_hi: got %0d expected 127", qget(qa_i, 2)); else n_pass++;
        n_checks++; if (qget(qa_r, 0) != 0) $display("FAIL sat_sum_zero: got %0d expected 0", qget(qa_r, 0)); else n_pass++;
    endtask

    task automatic test_scaling();
        clear();
        run_seq('{1, 0, 3, 0, 0, 0, 0, 0}, 4, 4);
        n_checks++; if (qget(qb_r, 0) != 2) $display("FAIL scale_sum: got %0d expected 2", qget(qb_r, 0)); else n_pass++;
        n_checks++; if (qget(qb_r, 2) != -1) $display("FAIL scale_diff_even: got %0d expected -1", qget(qb_r, 2)); else n_pass++;
        clear();
        run_seq('{0, 0, 3, 0, 0, 0, 0, 0}, 4, 4);
        n_checks++; if (qget(qb_r, 0) != 1) $display("FAIL scale_sum_floor: got %0d expected 1", qget(qb_r, 0)); else n_pass++;
        n_checks++; if (qget(qb_r, 2) != -2) $display("FAIL scale_diff_floor: got %0d expected -2", qget(qb_r, 2)); else n_pass++;
        n_checks++; if (qb_r.size() != 4) $display("FAIL scale_count: got %0d expected 4", qb_r.size()); else n_pass++;
    endtask

    task automatic test_err_drop();
        int e[4];
        e = '{4, 4, -2, -4};
        clear();
        step(1'b1, 1, -1);
        step(1'b0, 0, 0);
        n_checks++; if (a_err !== 1'b1) $display("FAIL drop_err_set: got %b expected 1", a_err); else n_pass++;
        step(1'b1, 3, -3);
        step(1'b1, 4, -4);
        for (int k = 0; k < 4; k++) step(1'b0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (qget(qa_r, k) != e[k]) $display("FAIL drop_r[%0d]: got %0d expected %0d", k, qget(qa_r, k), e[k]); else n_pass++;
        end
        n_checks++; if (a_err !== 1'b1 || b_err !== 1'b1) $display("FAIL drop_err_sticky: got %b/%b expected 1/1", a_err, b_err); else n_pass++;
    endtask

    task automatic test_err_flush();
        int e[4];
        e = '{4, 6, -2, -2};
        clear();
        run_seq('{1, 2, 3, 4, 0, 0, 0, 0}, 4, 1);
        n_checks++; if (a_err !== 1'b0) $display("FAIL flush_err_early: got %b expected 0", a_err); else n_pass++;
        step(1'b1, 9, -9);
        n_checks++; if (last_rdy !== 1'b0) $display("FAIL flush_ready: got %b expected 0", last_rdy); else n_pass++;
        n_checks++; if (a_err !== 1'b1) $display("FAIL flush_err: got %b expected 1", a_err); else n_pass++;
        for (int k = 0; k < 3; k++) step(1'b0, 0, 0);
        n_checks++; if (qa_r.size() != 4) $display("FAIL flush_count: got %0d expected 4", qa_r.size()); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (qget(qa_r, k) != e[k]) $display("FAIL flush_r[%0d]: got %0d expected %0d", k, qget(qa_r, k), e[k]); else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        int e[4];
        e = '{4, 6, -2, -2};
        clear();
        step(1'b1, 1, -1);
        step(1'b1, 2, -2);
        step(1'b1, 3, -3);
        n_checks++; if (a_ov !== 1'b1 || a_sof !== 1'b1) $display("FAIL mid_pre: got valid=%b sof=%b expected 1/1", a_ov, a_sof); else n_pass++;
        in_valid = 1'b1;
        din_r = 8'sd4;
        din_i = -8'sd4;
        rst = 1'b0;
        #1;
        n_checks++; if (a_dr !== 8'sd0 || a_ov !== 1'b0 || a_sof !== 1'b0) $display("FAIL mid_async: got data=%0d valid=%b sof=%b expected 0/0/0", a_dr, a_ov, a_sof); else n_pass++;
        n_checks++; if (a_shi_r !== 8'sd0 || a_rdy !== 1'b1 || a_err !== 1'b0) $display("FAIL mid_async_misc: got shin=%0d rdy=%b err=%b expected 0/1/0", a_shi_r, a_rdy, a_err); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        clear();
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
        run_seq('{1, 2, 3, 4, 0, 0, 0, 0}, 4, 4);
        n_checks++; if (qa_r.size() != 4) $display("FAIL mid_after_count: got %0d expected 4", qa_r.size()); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (qget(qa_r, k) != e[k]) $display("FAIL mid_after_r[%0d]: got %0d expected %0d", k, qget(qa_r, k), e[k]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_scaling();
        test_err_drop();
        test_reset();
        test_err_flush();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/r2sdf_butterfly.md
Name: r2sdf_butterfly

Overview:
- Radix-2 single-path delay-feedback butterfly stage controller for the pipelined FFT.
- Pairs with a delay line of depth DELAY. It drives the delay-line input and consumes the delay-line output.
- Emits one butterfly-processed stream per stage: first the sums, then the differences, of samples DELAY apart.
- The external delay line shifts every clock, so this block sequences frames, tracks validity, and handles drain and stream errors.

Parameters:
- WIDTH, 24, signed two's-complement sample width per component (R and I).
- DELAY, 8, half frame length; frame N = 2*DELAY; power of two, at least 2.
- SCALE, 1: 1 = arithmetic right shift by 1 (floor) of every butterfly result; 0 = saturate to signed WIDTH.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts input; 0 only in FLUSH.
- dataIn_R / dataIn_I  in  WIDTH each  input sample.
- shOut_R / shOut_I  in  WIDTH each  delay-line output (sample written DELAY cycles earlier).
- shIn_R / shIn_I  out  WIDTH each  delay-line input; combinational.
- dataOut_R / dataOut_I  out  WIDTH each  stage output; registered.
- out_valid  out  1  dataOut valid; registered.
- out_sof  out  1  marks the first sum of each frame; registered.
- err  out  1  sticky flag: in_valid dropped mid-frame, or in_valid high during FLUSH.

Behaviour:
- Reset, asynchronous while rst=0:
  - state IDLE, cnt=0.
  - dataOut=0, out_valid=0, out_sof=0, err=0.
  - in_ready=1, shIn=0.
  - Reset mid-frame discards all frame state. The delay-line contents are don't-care, because out_valid stays low until a new frame reaches its sum phase.
- Counter:
  - cnt is log2(2*DELAY) bits.
  - phase = cnt MSB: 0 = fill (cnt < DELAY), 1 = butterfly.
- Effective input x:
  - x = dataIn when in_valid=1 and state=RUN; otherwise x = 0.
- Datapath:
  - Internal arithmetic is WIDTH+1 bits; each result is reduced per SCALE.
  - Fill phase: shIn = x. Output register loads shOut, which holds the previous frame's differences.
  - Butterfly phase: shIn = reduce(shOut - x). Output register loads reduce(shOut + x).
  - R and I paths are independent and identical.
- FSM, IDLE:
  - Entered on reset or when FLUSH completes.
  - shIn=0, cnt=0.
  - in_valid=1 → state RUN with cnt=0. That same cycle's sample is frame sample 0 and is written to the delay line.
- FSM, RUN:
  - cnt increments every cycle and wraps 2*DELAY-1 → 0.
  - In any cycle with cnt=0 and in_valid=0: go to FLUSH, with the FLUSH counter starting that cycle.
  - in_valid=0 with cnt≠0: set err, use x=0, keep counting.
- FSM, FLUSH:
  - Lasts DELAY cycles; in_ready=0; x=0. Drains the last frame's differences.
  - in_valid=1 in any FLUSH cycle sets err; that sample is dropped.
  - Exit to IDLE after the final drain cycle.
- Output timing:
  - Register loads in cycle t and appears in t+1.
  - out_valid = 1 in t+1 when cycle t was a butterfly-phase RUN cycle, or a fill-phase cycle of a RUN or FLUSH that follows at least one completed butterfly phase.
  - out_sof = 1 with the sum of frame sample 0 (loaded at cnt=DELAY).
  - First sum appears DELAY+1 cycles after frame sample 0 enters.
- Output order per frame:
  - DELAY sums x[k]+x[k+DELAY] for k=0..DELAY-1.
  - Then DELAY differences x[k]-x[k+DELAY], emitted during the next frame's fill or during FLUSH.
- Back-to-back frames: continuous with no bubble; out_valid stays 1.
- Rounding: SCALE=1 uses floor (arithmetic shift). SCALE=0 clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].

Test Plan:
- Single frame, WIDTH=8, DELAY=2, SCALE=0:
  - Stimulus: in 1,2,3,4 then in_valid=0.
  - dataOut = 4,6,-2,-2 with out_valid high for exactly those 4 cycles.
  - out_sof only on the 4.
  - First output 3 cycles after sample 1; returns to IDLE; err=0.
- Back-to-back frames, same config:
  - Stimulus: 1,2,3,4,5,6,7,8.
  - Outputs 4,6,-2,-2,12,14,-2,-2 with no gap in out_valid.
  - out_sof on 4 and 12.
- Saturation, SCALE=0, WIDTH=8:
  - Frame 100,0,100,0 → sum 127 (clamped from 200).
  - Frame -100,0,100,0 → diff -128 (clamped from -200).
- Scaling, SCALE=1:
  - Frame 1,0,3,0 → sum 2.
  - Frame 0,0,3,0 → diff floor(-3/2) = -2.
- Errors:
  - in_valid dropped at cnt=1 → err=1 and stays 1; the missing sample is treated as 0 in the results.
  - in_valid=1 during FLUSH → err=1, in_ready=0 for those cycles.
- Reset mid-frame:
  - rst=0 at cnt=3 → all outputs 0 immediately (async).
  - After release, a new frame 1,2,3,4 produces exactly 4,6,-2,-2 with no stale data flagged valid.
